// File: rtl/seg_dynamic_param_if.sv
// Load/status bundle between the readout logic and seg_dynamic_param.
//   data     : unsigned magnitude to display
//   sign     : 1 = negative value
//   point    : decimal point per digit, bit0 = rightmost
//   load     : request a conversion (dropped while busy)
//   busy     : conversion in progress
//   overflow : committed frame is an overflow frame
interface seg_dynamic_param_if #(
    parameter int DIGITS = 6,
    parameter int DATA_W = 20
);
    logic [DATA_W-1:0] data;
    logic              sign;
    logic [DIGITS-1:0] point;
    logic              load;
    logic              busy;
    logic              overflow;

    modport master (output data, sign, point, load, input busy, overflow);
    modport slave  (input data, sign, point, load, output busy, overflow);
endinterface

// File: rtl/seg_dynamic_param.sv
// Multiplexed seven-segment driver: latches a signed magnitude and decimal
// points, converts to BCD with a shift-add-3 engine, builds a frame with
// leading-zero blanking, minus sign and overflow, then scans it out.
// Ports:
//   sys_clk  : system clock, rising edge
//   sys_rst  : synchronous active-high reset
//   bus      : load/status bundle (data, sign, point, load, busy, overflow)
//   seg_en   : 0 = display dark, scan keeps running
//   seg      : {dp,g,f,e,d,c,b,a} of the selected digit
//   sel      : one-hot digit select
//
// state   | meaning
// IDLE    | frame stable, waiting for load
// SHIFT   | one shift-add-3 iteration per cycle, DATA_W iterations
// COMMIT  | frame and overflow written from the finished BCD value
module seg_dynamic_param #(
    parameter int DIGITS      = 6,
    parameter int DATA_W      = 20,
    parameter int SCAN_DIV    = 50000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b0
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    seg_dynamic_param_if.slave bus,
    input  logic               seg_en,
    output logic [7:0]         seg,
    output logic [DIGITS-1:0]  sel
);
    // ceil(DATA_W * log10(2)) decimal digits, never fewer than DIGITS
    localparam int ND_MIN = (DATA_W * 30103 + 99999) / 100000;
    localparam int ND     = (ND_MIN > DIGITS) ? ND_MIN : DIGITS;
    localparam int SH_W   = 4 * ND + DATA_W;
    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int BIT_W  = $clog2(DATA_W + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [3:0] SYM_MINUS = 4'd10;
    localparam logic [3:0] SYM_BLANK = 4'd15;

    localparam logic [7:0]        SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [1:0]              state;
    logic [BIT_W-1:0]        bit_cnt;
    logic [SH_W-1:0]         sh;           // {bcd, remaining binary bits}
    logic                    sign_r;
    logic [DIGITS-1:0]       point_r;
    logic                    busy_q;
    logic                    ovf_q;
    logic [DIGITS-1:0][3:0]  frame_sym;
    logic [DIGITS-1:0]       frame_dp;
    logic [CNT_W-1:0]        scan_cnt;
    logic [IDX_W-1:0]        idx;
    logic [7:0]              seg_q;
    logic [DIGITS-1:0]       sel_q;

    logic [SH_W-1:0]         sh_adj;
    logic [SH_W-1:0]         sh_next;
    logic                    hi_nz;
    logic                    nz_run;
    logic                    pt_run;
    logic [DIGITS-1:0]       vis;
    logic [DIGITS-1:0]       minus_pos;
    logic                    ovf_c;
    logic [DIGITS-1:0][3:0]  sym_c;
    logic [DIGITS-1:0]       dp_c;
    logic [7:0]              seg_c;
    logic [DIGITS-1:0]       sel_raw;

    function automatic logic [7:0] seg_encode(input logic [3:0] sym, input logic dp);
        logic [6:0] code;
        logic [7:0] low;
        case (sym)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            4'd10:   code = 7'b0111111;
            default: code = 7'b1111111;
        endcase
        low = {~dp, code};
        return SEG_ACT_LOW ? low : ~low;
    endfunction

    always_comb begin
        sh_adj = sh;
        for (int k = 0; k < ND; k++) begin
            if (sh[DATA_W + 4*k +: 4] >= 4'd5)
                sh_adj[DATA_W + 4*k +: 4] = sh[DATA_W + 4*k +: 4] + 4'd3;
        end
        sh_next = {sh_adj[SH_W-2:0], 1'b0};
    end

    // Visibility is a thermometer from digit 0 upward, so the minus sign
    // sits at the first hidden digit just above the visible run.
    always_comb begin
        hi_nz = 1'b0;
        for (int k = DIGITS; k < ND; k++)
            hi_nz = hi_nz | (sh[DATA_W + 4*k +: 4] != 4'd0);
        nz_run = hi_nz;
        pt_run = 1'b0;
        vis    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz_run = nz_run | (sh[DATA_W + 4*k +: 4] != 4'd0);
            pt_run = pt_run | point_r[k];
            vis[k] = nz_run | pt_run | (k == 0);
        end
        minus_pos = {vis[DIGITS-2:0], 1'b0} & ~vis;
        ovf_c     = hi_nz | (sign_r & vis[DIGITS-1]);
        sym_c     = '0;
        dp_c      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (ovf_c) begin
                sym_c[k] = SYM_MINUS;
            end else if (vis[k]) begin
                sym_c[k] = sh[DATA_W + 4*k +: 4];
                dp_c[k]  = point_r[k];
            end else if (sign_r && minus_pos[k]) begin
                sym_c[k] = SYM_MINUS;
            end else begin
                sym_c[k] = SYM_BLANK;
                dp_c[k]  = point_r[k];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            sh        <= '0;
            sign_r    <= 1'b0;
            point_r   <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            frame_sym <= {DIGITS{SYM_BLANK}};
            frame_dp  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.load) begin
                        sh      <= {{(4*ND){1'b0}}, bus.data};
                        sign_r  <= bus.sign;
                        point_r <= bus.point;
                        bit_cnt <= BIT_W'(DATA_W);
                        busy_q  <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sh      <= sh_next;
                    bit_cnt <= bit_cnt - BIT_W'(1);
                    if (bit_cnt == BIT_W'(1))
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    frame_sym <= sym_c;
                    frame_dp  <= dp_c;
                    ovf_q     <= ovf_c;
                    busy_q    <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        seg_c   = seg_encode(frame_sym[idx], frame_dp[idx]);
        sel_raw = DIGITS'(1) << idx;
    end

    // seg and sel share one register stage so they always change together.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            seg_q <= SEG_OFF;
            sel_q <= SEL_OFF;
        end else if (seg_en) begin
            seg_q <= seg_c;
            sel_q <= SEL_ACT_LOW ? ~sel_raw : sel_raw;
        end else begin
            seg_q <= SEG_OFF;
            sel_q <= SEL_OFF;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
    assign seg          = seg_q;
    assign sel          = sel_q;
endmodule

// File: tb/tb_seg_dynamic_param.sv
// Scoreboard bench for seg_dynamic_param: a decimal model pushes the expected
// per-digit segment codes when a value is loaded, and they are popped when the
// scan presents each digit on the pins.
module tb_seg_dynamic_param;
    localparam int DIGITS   = 6;
    localparam int DATA_W   = 20;
    localparam int SCAN_DIV = 4;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              seg_en;
    logic [7:0]        seg;
    logic [DIGITS-1:0] sel;

    seg_dynamic_param_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus_if ();

    seg_dynamic_param #(
        .DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV),
        .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b0)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus_if),
        .seg_en(seg_en), .seg(seg), .sel(sel)
    );

    always #5 sys_clk = ~sys_clk;

    int         errors = 0;
    int         checks = 0;
    int         scan_n = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf;

    // edges since reset release; drives the expected scan position
    always @(posedge sys_clk) begin
        if (sys_rst) scan_n <= 0;
        else         scan_n <= scan_n + 1;
    end

    function automatic int exp_idx(int n);
        return ((n - 1) / SCAN_DIV) % DIGITS;
    endfunction

    function automatic logic [DIGITS-1:0] exp_sel(int n);
        if (n <= 0) return '0;
        return DIGITS'(1) << exp_idx(n);
    endfunction

    function automatic logic [7:0] ref_seg(int sym, logic dp);
        logic [6:0] c;
        case (sym)
            0: c = 7'b1000000;  1: c = 7'b1111001;  2: c = 7'b0100100;
            3: c = 7'b0110000;  4: c = 7'b0011001;  5: c = 7'b0010010;
            6: c = 7'b0000010;  7: c = 7'b1111000;  8: c = 7'b0000000;
            9: c = 7'b0010000;  10: c = 7'b0111111;
            default: c = 7'b1111111;
        endcase
        return {~dp, c};
    endfunction

    task automatic push_model(int value, logic sgn, logic [DIGITS-1:0] pt);
        int   d[7];
        int   v;
        int   h;
        logic shown;
        logic ovf;
        v = value;
        for (int i = 0; i < 7; i++) begin
            d[i] = v % 10;
            v    = v / 10;
        end
        h = 0;
        for (int k = 0; k < DIGITS; k++) begin
            shown = (d[k] != 0) || (k == 0);
            for (int j = k + 1; j < 7; j++) if (d[j] != 0) shown = 1'b1;
            for (int j = k; j < DIGITS; j++) if (pt[j]) shown = 1'b1;
            if (shown) h = k;
        end
        ovf     = (d[6] != 0) || (sgn && h == DIGITS - 1);
        exp_ovf = ovf;
        for (int k = 0; k < DIGITS; k++) begin
            if (ovf)                    exp_q.push_back(ref_seg(10, 1'b0));
            else if (k <= h)            exp_q.push_back(ref_seg(d[k], pt[k]));
            else if (sgn && k == h + 1) exp_q.push_back(ref_seg(10, 1'b0));
            else                        exp_q.push_back(ref_seg(15, pt[k]));
        end
    endtask

    // Ends at the negedge after the edge that accepted the load.
    task automatic start_load(int value, logic sgn, logic [DIGITS-1:0] pt);
        @(negedge sys_clk);
        bus_if.data  = DATA_W'(value);
        bus_if.sign  = sgn;
        bus_if.point = pt;
        bus_if.load  = 1'b1;
        @(negedge sys_clk);
        bus_if.load  = 1'b0;
    endtask

    task automatic wait_idle(output int hi);
        hi = 0;
        while (bus_if.busy === 1'b1 && hi < 200) begin
            hi++;
            @(negedge sys_clk);
        end
    endtask

    task automatic read_frame(string name);
        logic [7:0]        e;
        logic [DIGITS-1:0] want;
        int                n;
        @(negedge sys_clk);
        for (int k = 0; k < DIGITS; k++) begin
            want = DIGITS'(1) << k;
            n = 0;
            while (sel !== want && n < 40) begin
                n++;
                @(negedge sys_clk);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            checks++;
            if (sel !== want) begin
                errors++;
                $display("FAIL %s timeout digit %0d: sel=%b required %b", name, k, sel, want);
            end else if (seg !== e) begin
                errors++;
                $display("FAIL %s digit %0d: seg=%b required %b", name, k, seg, e);
            end
        end
    endtask

    task automatic test_convert(string name, int value, logic sgn, logic [DIGITS-1:0] pt);
        int hi;
        push_model(value, sgn, pt);
        start_load(value, sgn, pt);
        wait_idle(hi);
        checks++;
        if (hi != DATA_W + 1) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, hi, DATA_W + 1);
        end
        checks++;
        if (bus_if.overflow !== exp_ovf) begin
            errors++;
            $display("FAIL %s overflow: got %b required %b", name, bus_if.overflow, exp_ovf);
        end
        read_frame(name);
    endtask

    task automatic test_reset();
        sys_rst      = 1'b1;
        seg_en       = 1'b1;
        bus_if.data  = DATA_W'(777);
        bus_if.sign  = 1'b0;
        bus_if.point = '0;
        bus_if.load  = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (seg !== 8'hFF || sel !== '0 || bus_if.busy !== 1'b0 || bus_if.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: seg=%h sel=%b busy=%b ovf=%b required FF 000000 0 0",
                     seg, sel, bus_if.busy, bus_if.overflow);
        end
        bus_if.load = 1'b0;
        sys_rst     = 1'b0;
        for (int c = 0; c < 28; c++) begin
            @(negedge sys_clk);
            checks++;
            if (sel !== exp_sel(scan_n) || seg !== 8'hFF) begin
                errors++;
                $display("FAIL reset_scan n=%0d: sel=%b seg=%h required %b FF",
                         scan_n, sel, seg, exp_sel(scan_n));
            end
        end
    endtask

    task automatic test_load_while_busy();
        int hi;
        push_model(4321, 1'b0, '0);
        start_load(4321, 1'b0, '0);
        repeat (4) @(negedge sys_clk);
        bus_if.data = DATA_W'(987);
        bus_if.load = 1'b1;
        @(negedge sys_clk);
        bus_if.load = 1'b0;
        wait_idle(hi);
        checks++;
        if (hi != DATA_W - 4) begin
            errors++;
            $display("FAIL load_while_busy busy_left: got %0d required %0d", hi, DATA_W - 4);
        end
        read_frame("load_while_busy");
    endtask

    task automatic test_back_to_back();
        int hi;
        push_model(1000000, 1'b0, '0);
        exp_q.delete();
        start_load(1000000, 1'b0, '0);
        wait_idle(hi);
        checks++;
        if (hi != DATA_W + 1 || bus_if.overflow !== exp_ovf) begin
            errors++;
            $display("FAIL b2b_first: busy_cycles=%0d ovf=%b required %0d %b",
                     hi, bus_if.overflow, DATA_W + 1, exp_ovf);
        end
        bus_if.data  = DATA_W'(321);
        bus_if.sign  = 1'b0;
        bus_if.point = 6'b000010;
        bus_if.load  = 1'b1;
        @(negedge sys_clk);
        bus_if.load  = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b required 1", bus_if.busy);
        end
        push_model(321, 1'b0, 6'b000010);
        wait_idle(hi);
        checks++;
        if (hi != DATA_W + 1 || bus_if.overflow !== exp_ovf) begin
            errors++;
            $display("FAIL b2b_second: busy_cycles=%0d ovf=%b required %0d %b",
                     hi, bus_if.overflow, DATA_W + 1, exp_ovf);
        end
        read_frame("back_to_back");
    endtask

    task automatic test_reset_mid_conv();
        int hi;
        start_load(1000000, 1'b0, '0);
        wait_idle(hi);
        start_load(12345, 1'b0, '0);
        repeat (9) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_conv: busy=%b ovf=%b required 0 0", bus_if.busy, bus_if.overflow);
        end
        sys_rst = 1'b0;
        repeat (DIGITS) exp_q.push_back(8'hFF);
        read_frame("reset_mid_conv");
    endtask

    task automatic test_seg_en();
        int         hi;
        logic [7:0] frm[DIGITS];
        push_model(123456, 1'b0, 6'b001000);
        for (int k = 0; k < DIGITS; k++) frm[k] = exp_q.pop_front();
        start_load(123456, 1'b0, 6'b001000);
        wait_idle(hi);
        repeat (7) @(negedge sys_clk);
        seg_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            checks++;
            if (seg !== 8'hFF || sel !== '0) begin
                errors++;
                $display("FAIL seg_en_dark c=%0d: seg=%h sel=%b required FF 000000", c, seg, sel);
            end
        end
        seg_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge sys_clk);
            checks++;
            if (sel !== exp_sel(scan_n) || seg !== frm[exp_idx(scan_n)]) begin
                errors++;
                $display("FAIL seg_en_resume c=%0d: sel=%b seg=%b required %b %b",
                         c, sel, seg, exp_sel(scan_n), frm[exp_idx(scan_n)]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert("d12345",    12345,   1'b0, 6'b000000);
        test_convert("neg42_dp",  42,      1'b1, 6'b000100);
        test_convert("ovf_7dig",  1000000, 1'b0, 6'b000000);
        test_convert("ovf_sign",  100000,  1'b1, 6'b000000);
        test_convert("neg99999",  99999,   1'b1, 6'b000000);
        test_convert("zero",      0,       1'b0, 6'b000000);
        test_convert("d999999",   999999,  1'b0, 6'b000000);
        test_convert("max_in",    1048575, 1'b0, 6'b000000);
        test_convert("neg7_dp",   7,       1'b1, 6'b000010);
        test_load_while_busy();
        test_back_to_back();
        test_reset_mid_conv();
        test_seg_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
